// File: rtl/obj_detect_tx.sv
// rtl/obj_detect_tx.sv - serial transmitter for an 8-flag detector snapshot.
// Sends start, 8 data bits LSB first, an even-parity bit and a stop bit when the snapshot changes or on request.
module obj_detect_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic front_detected,
    input  logic left_detected,
    input  logic right_detected,
    input  logic back_detected,
    input  logic front_right_detected,
    input  logic front_left_detected,
    input  logic back_right_detected,
    input  logic back_left_detected,
    input  logic force_send,
    output logic tx_serial,
    output logic tx_busy,
    output logic frame_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam logic [15:0] LP_LAST = 16'(CLKS_PER_BIT - 1);

    state_t      r_state;
    logic [7:0]  r_snap;
    logic [7:0]  r_shadow;
    logic [7:0]  r_last_sent;
    logic        r_pend;
    logic [15:0] r_cnt;
    logic [2:0]  r_bit_idx;
    logic        r_tx;

    state_t      w_state_nxt;
    logic [7:0]  w_flags;
    logic [7:0]  w_shadow_nxt;
    logic [7:0]  w_last_nxt;
    logic        w_pend_nxt;
    logic [15:0] w_cnt_nxt;
    logic [2:0]  w_bit_nxt;
    logic [2:0]  w_bit_inc;
    logic        w_tx_nxt;
    logic        w_bit_end;
    logic        w_frame_done;

    assign w_flags = {back_left_detected, back_right_detected,
                      front_left_detected, front_right_detected,
                      back_detected, right_detected,
                      left_detected, front_detected};

    assign w_bit_end = (r_cnt == LP_LAST);
    assign w_bit_inc = r_bit_idx + 3'd1;

    assign tx_serial  = r_tx;
    assign tx_busy    = (r_state != S_IDLE);
    assign frame_done = w_frame_done;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_snap      <= 8'd0;
            r_shadow    <= 8'd0;
            r_last_sent <= 8'd0;
            r_pend      <= 1'b0;
            r_cnt       <= 16'd0;
            r_bit_idx   <= 3'd0;
            r_tx        <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_snap      <= w_flags;
            r_shadow    <= w_shadow_nxt;
            r_last_sent <= w_last_nxt;
            r_pend      <= w_pend_nxt;
            r_cnt       <= w_cnt_nxt;
            r_bit_idx   <= w_bit_nxt;
            r_tx        <= w_tx_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_shadow_nxt = r_shadow;
        w_last_nxt   = r_last_sent;
        w_pend_nxt   = r_pend | force_send;
        w_cnt_nxt    = w_bit_end ? 16'd0 : r_cnt + 16'd1;
        w_bit_nxt    = r_bit_idx;
        w_tx_nxt     = r_tx;
        w_frame_done = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = 16'd0;
                w_bit_nxt = 3'd0;
                w_tx_nxt  = 1'b1;
                // A force_send landing on the launch edge is satisfied by this frame.
                if ((r_snap != r_last_sent) || r_pend) begin
                    w_state_nxt  = S_START;
                    w_shadow_nxt = r_snap;
                    w_last_nxt   = r_snap;
                    w_pend_nxt   = 1'b0;
                    w_tx_nxt     = 1'b0;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_nxt = S_DATA;
                    w_bit_nxt   = 3'd0;
                    w_tx_nxt    = r_shadow[0];
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = S_PARITY;
                        w_tx_nxt    = ^r_shadow;
                    end else begin
                        w_bit_nxt = w_bit_inc;
                        w_tx_nxt  = r_shadow[w_bit_inc];
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = S_STOP;
                    w_tx_nxt    = 1'b1;
                end
            end
            S_STOP: begin
                w_tx_nxt = 1'b1;
                if (w_bit_end) begin
                    w_state_nxt  = S_IDLE;
                    w_frame_done = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_obj_detect_tx.sv
// tb/tb_obj_detect_tx.sv - directed self-checking bench for obj_detect_tx with 4 clocks per bit.
module tb_obj_detect_tx;

    localparam int CPB = 4;
    localparam int FRAME = 11 * CPB;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic front_detected = 1'b0, left_detected = 1'b0, right_detected = 1'b0, back_detected = 1'b0;
    logic front_right_detected = 1'b0, front_left_detected = 1'b0;
    logic back_right_detected = 1'b0, back_left_detected = 1'b0;
    logic force_send = 1'b0;
    logic tx_serial, tx_busy, frame_done;

    int vectors = 0;
    int miscompares = 0;

    obj_detect_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk),
        .reset(reset),
        .front_detected(front_detected),
        .left_detected(left_detected),
        .right_detected(right_detected),
        .back_detected(back_detected),
        .front_right_detected(front_right_detected),
        .front_left_detected(front_left_detected),
        .back_right_detected(back_right_detected),
        .back_left_detected(back_left_detected),
        .force_send(force_send),
        .tx_serial(tx_serial),
        .tx_busy(tx_busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_flags(input logic [7:0] v);
        {back_left_detected, back_right_detected, front_left_detected, front_right_detected,
         back_detected, right_detected, left_detected, front_detected} = v;
    endtask

    task automatic check_idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk(tag, int'({tx_serial, tx_busy, frame_done}), 3'b100);
        end
    endtask

    task automatic wait_fall(input string tag, input int max_wait, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_wait; i++) begin
            @(negedge clk);
            if (tx_serial === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        chk({tag, "_start"}, int'(ok), 1);
    endtask

    // Checks every cycle of one frame; optionally changes flags or pulses force_send mid-frame.
    task automatic expect_frame(input string tag, input logic [7:0] data, input int max_wait,
                                input int chg_cycle, input logic [7:0] chg_val,
                                input int fa, input int fb);
        bit ok;
        int bitn;
        logic exp_bit;
        wait_fall(tag, max_wait, ok);
        if (!ok) return;
        for (int c = 0; c < FRAME; c++) begin
            if (c > 0) @(negedge clk);
            bitn = c / CPB;
            if (bitn == 0)      exp_bit = 1'b0;
            else if (bitn <= 8) exp_bit = data[bitn-1];
            else if (bitn == 9) exp_bit = ^data;
            else                exp_bit = 1'b1;
            chk({tag, "_tx"}, int'(tx_serial), int'(exp_bit));
            chk({tag, "_busy"}, int'(tx_busy), 1);
            chk({tag, "_done"}, int'(frame_done), int'(c == FRAME - 1));
            if (c == chg_cycle) set_flags(chg_val);
            force_send = (c == fa) || (c == fb);
        end
        @(negedge clk);
        force_send = 1'b0;
        chk({tag, "_end_busy"}, int'(tx_busy), 0);
        chk({tag, "_end_tx"}, int'(tx_serial), 1);
    endtask

    initial begin
        bit ok;

        // Reset held low for 3 cycles, then quiet line for 100 cycles.
        @(negedge clk);
        chk("rst_state", int'({tx_serial, tx_busy, frame_done}), 3'b100);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        check_idle("quiet", 100);

        // Single front flag: latency check then frame 0x01.
        set_flags(8'h01);
        @(negedge clk);
        chk("lat_k", int'(tx_serial), 1);
        expect_frame("f01", 8'h01, 1, -1, 8'h00, -1, -1);
        check_idle("f01_hold", 10);

        // Front, right, front-right.
        set_flags(8'h15);
        expect_frame("f15", 8'h15, 3, -1, 8'h00, -1, -1);
        check_idle("f15_hold", 5);

        // Mid-frame change must not corrupt the running frame; new value follows after one idle cycle.
        set_flags(8'h01);
        expect_frame("f01b", 8'h01, 3, 10, 8'h80, -1, -1);
        expect_frame("f80", 8'h80, 1, -1, 8'h00, -1, -1);
        check_idle("f80_hold", 5);

        // Reset during data bit 3 aborts the frame.
        set_flags(8'h55);
        wait_fall("rst_mid", 3, ok);
        repeat (17) @(negedge clk);
        chk("rst_mid_busy", int'(tx_busy), 1);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_abort", int'({tx_serial, tx_busy, frame_done}), 3'b100);
        set_flags(8'h08);
        reset = 1'b1;
        expect_frame("f08", 8'h08, 3, -1, 8'h00, -1, -1);
        check_idle("f08_hold", 5);

        // Clearing flags sends 0x00 (parity 0).
        set_flags(8'h00);
        expect_frame("f00", 8'h00, 3, -1, 8'h00, -1, -1);
        check_idle("f00_hold", 5);

        // force_send while idle, then two pulses during the frame yield exactly one more frame.
        force_send = 1'b1;
        @(negedge clk);
        force_send = 1'b0;
        chk("force_lat", int'(tx_serial), 1);
        expect_frame("force1", 8'h00, 1, -1, 8'h00, 10, 20);
        expect_frame("force2", 8'h00, 1, -1, 8'h00, -1, -1);
        check_idle("force_hold", 20);

        // force_send coinciding with a flag change yields a single frame.
        set_flags(8'h3C);
        force_send = 1'b1;
        @(negedge clk);
        force_send = 1'b0;
        chk("coin_lat", int'(tx_serial), 1);
        expect_frame("f3c", 8'h3C, 1, -1, 8'h00, -1, -1);
        check_idle("f3c_hold", 20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/obj_detect_tx.md
OBJ_DETECT_TX -- requirements
Module: obj_detect_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clock cycles per serial bit; legal range 2..65535.
REQ-002 clk  input  1  system clock; all logic on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; sampled on the clk rising edge.
REQ-004 front_detected, left_detected, right_detected, back_detected  input  1 each  detector flags.
REQ-005 front_right_detected, front_left_detected, back_right_detected, back_left_detected  input  1 each  detector flags.
REQ-006 force_send  input  1  single-cycle request to transmit the current snapshot even if unchanged.
REQ-007 tx_serial  output  1  serial line, idle high.
REQ-008 tx_busy  output  1  high while a frame is in progress (START through STOP).
REQ-009 frame_done  output  1  one-cycle pulse at completion of each frame.

Function
REQ-010 Each cycle, the block shall register the 8 flags into snap as {BL,BR,FL,FR,B,R,L,F}, with F as bit 0.
REQ-011 The FSM shall have states IDLE, START, DATA, PARITY, STOP.
REQ-012 IDLE -> START when (snap != last_sent) or pend; the same edge shall load shadow<=snap and last_sent<=snap, clear pend, and drive tx_serial<=0.
REQ-013 Latency: a flag change present at edge k reaches snap at k; tx_serial shall go low after edge k+1.
REQ-014 START shall hold tx_serial=0 for CLKS_PER_BIT cycles, then go to DATA.
REQ-015 DATA shall send shadow[0]..shadow[7] LSB first, CLKS_PER_BIT cycles each, using a 3-bit bit index; after bit 7 go to PARITY.
REQ-016 PARITY shall send the even-parity bit (XOR of shadow[7:0]) for CLKS_PER_BIT cycles.
REQ-017 STOP shall hold tx_serial=1 for CLKS_PER_BIT cycles.
REQ-018 On the last STOP cycle, frame_done shall be 1 for exactly that cycle, and the next state shall be IDLE.
REQ-019 A frame shall be 11*CLKS_PER_BIT cycles from tx_serial falling to the return to IDLE.
REQ-020 The minimum IDLE dwell between frames shall be 1 cycle.
REQ-021 The bit-period counter shall be 16 bits wide and count 0..CLKS_PER_BIT-1, wrapping to 0 on each bit boundary.
REQ-022 Flag changes during a frame shall not alter shadow.
REQ-023 After STOP, IDLE shall compare the latest snap with last_sent, so intermediate values may be coalesced but the final value is always sent.
REQ-024 force_send in IDLE shall set pend, causing a frame on the next edge.
REQ-025 force_send while tx_busy shall set pend, which is served after the current frame.
REQ-026 Multiple force_send pulses before service shall yield a single frame.
REQ-027 If force_send coincides with a flag change in IDLE, exactly one frame shall be sent.
REQ-028 tx_busy shall be 1 in START, DATA, PARITY and STOP, and 0 in IDLE.

Reset
REQ-029 While reset=0 at an edge, state<=IDLE, tx_serial<=1, tx_busy<=0, frame_done<=0, snap<=0, shadow<=0, last_sent<=0, pend<=0, counters<=0.
REQ-030 Reset mid-frame shall abort the frame; tx_serial shall be 1 after that edge, with no partial-frame resumption.
REQ-031 After reset release with all flags 0, no frame shall be sent (snap == last_sent == 0).

Verification (CLKS_PER_BIT=4, frame=44 cycles)
REQ-032 Reset low 3 cycles, then high, flags 0 for 100 cycles -> tx_serial=1, tx_busy=0, frame_done never pulses.
REQ-033 front_detected=1 only -> line 0,1,0,0,0,0,0,0,0,1,1 (data 0x01, parity 1), each bit 4 cycles; frame_done pulses once.
REQ-034 front_detected=1, right_detected=1, front_right_detected=1 -> data 0x15, parity 1; tx_busy high for exactly 44 cycles.
REQ-035 Flags 0x01 then 0x80 mid-frame -> frame 0x01 completes unchanged; 0x80 frame (parity 1) starts after 1 IDLE cycle.
REQ-036 Reset low during DATA bit 3 -> tx_serial=1 and tx_busy=0 next edge; after release, flags 0x08 -> complete 0x08 frame.
REQ-037 Flags steady 0, force_send pulse -> data 0x00, parity 0; second pulse during frame -> exactly one more 0x00 frame.
